// File: rtl/i2c_init_seq.sv
// ---------------------------------------------------------------------------
// i2c_init_seq
//
// I2C register-initialisation sequencer. It walks an external init table of
// {sub_addr, data} entries and hands each entry to the byte-level i2c master
// as a write to SLAVE_ADDR. A NACKed write is resent until MAX_RETRY attempts
// have been made, after which the run stops with error/err_index. The entry
// 16'hFFFF ends the table. A start pulse (re)runs the table from index 0.
// A start that arrives mid-run is remembered and taken at the next entry
// boundary, so a transaction is never cut short.
//
// Optional feature (macro I2C_INIT_SEQ_DELAY_EN):
//   defined   - entries 16'hFEnn are delays of nn*DELAY_UNIT clocks with no
//               I2C traffic.
//   undefined - 16'hFEnn is an ordinary write to sub-address 0xFE; the delay
//               state and its counter do not exist.
//
// Ports:
//   iCLK       system clock
//   iRST_N     asynchronous active-low reset
//   start      single-cycle pulse: run or re-run the table from index 0
//   tbl_addr   table read index
//   tbl_data   table entry {sub_addr, data}, valid one cycle after tbl_addr
//   i2c_data   {SLAVE_ADDR, entry}, stable while i2c_start is high
//   i2c_start  transaction request to the i2c master
//   i2c_end    master idle/complete; low while a transfer is in progress
//   i2c_ack    sampled with i2c_end: 0 = ACK, 1 = NACK
//   busy       sequence running
//   done       end marker reached cleanly; sticky until the next run
//   error      an entry ran out of retries; sticky until the next run
//   err_index  index of the failing entry
// ---------------------------------------------------------------------------
module i2c_init_seq #(
   parameter logic [7:0] SLAVE_ADDR = 8'h98,
   parameter int         IDX_W      = 8,
   parameter int         MAX_RETRY  = 3,
   parameter int         DELAY_UNIT = 27000,
   parameter int         AUTO_START = 1
) (
   input  logic             iCLK,
   input  logic             iRST_N,
   input  logic             start,
   output logic [IDX_W-1:0] tbl_addr,
   input  logic [15:0]      tbl_data,
   output logic [23:0]      i2c_data,
   output logic             i2c_start,
   input  logic             i2c_end,
   input  logic             i2c_ack,
   output logic             busy,
   output logic             done,
   output logic             error,
   output logic [IDX_W-1:0] err_index
);

   typedef enum logic [3:0] {
      IDLE,
      FETCH,
      DECODE,
      GO,
      ACCEPT,
      WAIT_END,
`ifdef I2C_INIT_SEQ_DELAY_EN
      DELAY,
`endif
      DONE,
      FAIL
   } state_t;

   localparam logic [IDX_W-1:0] IDX_LAST  = '1;
   localparam logic [3:0]       RETRY_TOP = 4'(MAX_RETRY - 1);

   state_t           state;
   state_t           state_nxt;
   logic [IDX_W-1:0] idx;
   logic [15:0]      entry;
   logic             fetch_phase;
   logic [3:0]       retry;
   logic             pending;
   logic             first_cyc;

   logic             restart_req;
   logic             launch;
   logic             restart;
   logic             advance;
   logic             retry_again;
   logic             fetch_latch;
   logic             load_write;
   logic             set_done;
   logic             set_error;

`ifdef I2C_INIT_SEQ_DELAY_EN
   localparam int CNT_W = $clog2(255 * DELAY_UNIT + 1);
   logic [CNT_W-1:0] dly_cnt;
   logic             load_delay;
`endif

   // A start arriving in the very cycle of an entry boundary counts the same
   // as one remembered earlier.
   assign restart_req = pending | start;
   assign tbl_addr    = idx;

   // State register.
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic plus the one-cycle strobes that steer the datapath.
   always_comb begin
      state_nxt   = state;
      launch      = 1'b0;
      restart     = 1'b0;
      advance     = 1'b0;
      retry_again = 1'b0;
      fetch_latch = 1'b0;
      load_write  = 1'b0;
      set_done    = 1'b0;
      set_error   = 1'b0;
`ifdef I2C_INIT_SEQ_DELAY_EN
      load_delay  = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (start || (first_cyc && (AUTO_START != 0))) begin
               launch    = 1'b1;
               state_nxt = FETCH;
            end
         end
         FETCH: begin
            // First cycle presents the index, second captures the table word.
            if (fetch_phase) begin
               fetch_latch = 1'b1;
               state_nxt   = DECODE;
            end
         end
         DECODE: begin
            if (entry == 16'hFFFF) begin
               state_nxt = DONE;
`ifdef I2C_INIT_SEQ_DELAY_EN
            end else if (entry[15:8] == 8'hFE) begin
               load_delay = 1'b1;
               state_nxt  = DELAY;
`endif
            end else begin
               load_write = 1'b1;
               state_nxt  = GO;
            end
         end
         GO: begin
            state_nxt = ACCEPT;
         end
         ACCEPT: begin
            if (!i2c_end) begin
               state_nxt = WAIT_END;
            end
         end
         WAIT_END: begin
            if (i2c_end) begin
               if (restart_req) begin
                  restart   = 1'b1;
                  state_nxt = FETCH;
               end else if (!i2c_ack) begin
                  if (idx == IDX_LAST) begin
                     state_nxt = DONE;
                  end else begin
                     advance   = 1'b1;
                     state_nxt = FETCH;
                  end
               end else if (retry == RETRY_TOP) begin
                  state_nxt = FAIL;
               end else begin
                  retry_again = 1'b1;
                  state_nxt   = GO;
               end
            end
         end
`ifdef I2C_INIT_SEQ_DELAY_EN
         DELAY: begin
            if (dly_cnt <= CNT_W'(1)) begin
               if (restart_req) begin
                  restart   = 1'b1;
                  state_nxt = FETCH;
               end else if (idx == IDX_LAST) begin
                  state_nxt = DONE;
               end else begin
                  advance   = 1'b1;
                  state_nxt = FETCH;
               end
            end
         end
`endif
         DONE: begin
            if (restart_req) begin
               restart   = 1'b1;
               state_nxt = FETCH;
            end else begin
               set_done  = 1'b1;
               state_nxt = IDLE;
            end
         end
         FAIL: begin
            if (restart_req) begin
               restart   = 1'b1;
               state_nxt = FETCH;
            end else begin
               set_error = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Datapath: table index, fetched entry, retry count, pending restart and
   // the first-cycle marker used for AUTO_START.
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         idx         <= '0;
         entry       <= '0;
         fetch_phase <= 1'b0;
         retry       <= '0;
         pending     <= 1'b0;
         first_cyc   <= 1'b1;
      end else begin
         first_cyc <= 1'b0;

         if (launch || restart) begin
            pending <= 1'b0;
         end else if (start && (state != IDLE)) begin
            pending <= 1'b1;
         end

         if (state == FETCH) begin
            fetch_phase <= ~fetch_phase;
         end else begin
            fetch_phase <= 1'b0;
         end

         if (launch || restart) begin
            idx <= '0;
         end else if (advance) begin
            idx <= idx + 1'b1;
         end

         if (fetch_latch) begin
            entry <= tbl_data;
         end

         if (launch || restart || advance ||
             ((state == WAIT_END) && i2c_end && !i2c_ack)) begin
            retry <= '0;
         end else if (retry_again) begin
            retry <= retry + 1'b1;
         end
      end
   end

   // Master handshake: the request rises out of GO and is held through
   // ACCEPT until the master shows it has taken the transfer.
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         i2c_data  <= '0;
         i2c_start <= 1'b0;
      end else begin
         if (load_write) begin
            i2c_data <= {SLAVE_ADDR, entry};
         end
         if (state == GO) begin
            i2c_start <= 1'b1;
         end else if ((state == ACCEPT) && !i2c_end) begin
            i2c_start <= 1'b0;
         end
      end
   end

   // Status flags. done/error are only raised when a run really finishes,
   // so a run aborted by a restart leaves them clear.
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         busy      <= 1'b0;
         done      <= 1'b0;
         error     <= 1'b0;
         err_index <= '0;
      end else begin
         if (launch) begin
            busy  <= 1'b1;
            done  <= 1'b0;
            error <= 1'b0;
         end else if (set_done) begin
            busy <= 1'b0;
            done <= 1'b1;
         end else if (set_error) begin
            busy      <= 1'b0;
            error     <= 1'b1;
            err_index <= idx;
         end
      end
   end

`ifdef I2C_INIT_SEQ_DELAY_EN
   // Delay tick counter, loaded with nn*DELAY_UNIT and counted down to one
   // so that the state is occupied for exactly that many clocks.
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         dly_cnt <= '0;
      end else if (load_delay) begin
         dly_cnt <= CNT_W'(entry[7:0]) * CNT_W'(DELAY_UNIT);
      end else if ((state == DELAY) && (dly_cnt > CNT_W'(1))) begin
         dly_cnt <= dly_cnt - 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_i2c_init_seq.sv
// ---------------------------------------------------------------------------
// tb_i2c_init_seq
//
// Directed bench for i2c_init_seq. A registered table ROM and a small i2c
// master model (accepts a request, stays busy a few clocks, then reports ACK
// or a programmed NACK) surround the main instance (AUTO_START=1). A second
// instance with AUTO_START=0 shows that nothing happens until start.
// ---------------------------------------------------------------------------
module tb_i2c_init_seq;

   localparam int IDX_W = 8;

   logic             iCLK = 1'b0;
   logic             iRST_N;
   logic             start;
   logic [IDX_W-1:0] tbl_addr;
   logic [15:0]      tbl_data = 16'h0000;
   logic [23:0]      i2c_data;
   logic             i2c_start;
   logic             i2c_end;
   logic             i2c_ack;
   logic             busy;
   logic             done;
   logic             error;
   logic [IDX_W-1:0] err_index;

   logic             start0;
   logic [IDX_W-1:0] tbl_addr0;
   logic [23:0]      i2c_data0;
   logic             i2c_start0;
   logic             busy0;
   logic             done0;
   logic             error0;
   logic [IDX_W-1:0] err_index0;

   logic [15:0]      rom [0:255];
   logic [23:0]      log_q [$];
   int               first_acc_cyc;
   int               cyc = 0;
   logic [23:0]      nack_target;
   int               nack_left;
   bit               nack_always;
   bit               start0_seen;
   int               act0 = 0;

   int               check_count = 0;
   int               pass_count  = 0;

   always #5 iCLK = ~iCLK;

   i2c_init_seq #(
      .SLAVE_ADDR (8'h98),
      .IDX_W      (IDX_W),
      .MAX_RETRY  (3),
      .DELAY_UNIT (10),
      .AUTO_START (1)
   ) u_dut (
      .iCLK      (iCLK),
      .iRST_N    (iRST_N),
      .start     (start),
      .tbl_addr  (tbl_addr),
      .tbl_data  (tbl_data),
      .i2c_data  (i2c_data),
      .i2c_start (i2c_start),
      .i2c_end   (i2c_end),
      .i2c_ack   (i2c_ack),
      .busy      (busy),
      .done      (done),
      .error     (error),
      .err_index (err_index)
   );

   i2c_init_seq #(
      .SLAVE_ADDR (8'h98),
      .IDX_W      (IDX_W),
      .MAX_RETRY  (3),
      .DELAY_UNIT (10),
      .AUTO_START (0)
   ) u_dut_manual (
      .iCLK      (iCLK),
      .iRST_N    (iRST_N),
      .start     (start0),
      .tbl_addr  (tbl_addr0),
      .tbl_data  (16'hFFFF),
      .i2c_data  (i2c_data0),
      .i2c_start (i2c_start0),
      .i2c_end   (1'b1),
      .i2c_ack   (1'b0),
      .busy      (busy0),
      .done      (done0),
      .error     (error0),
      .err_index (err_index0)
   );

   // Registered table ROM: data follows the address by one clock.
   always @(posedge iCLK) begin
      tbl_data <= rom[tbl_addr];
      cyc      <= cyc + 1;
   end

   // Any activity on the manual instance before its start is counted.
   always @(posedge iCLK) begin
      if (!start0_seen && (busy0 || i2c_start0)) begin
         act0 <= act0 + 1;
      end
   end

   // i2c master model: take a request, hold i2c_end low four clocks, then
   // finish with ACK, or NACK when the write matches the programmed target.
   initial begin
      logic [23:0] cur;
      i2c_end = 1'b1;
      i2c_ack = 1'b0;
      forever begin
         @(posedge iCLK);
         #1;
         if (iRST_N && i2c_start && i2c_end) begin
            cur = i2c_data;
            log_q.push_back(cur);
            if (log_q.size() == 1) begin
               first_acc_cyc = cyc;
            end
            i2c_end = 1'b0;
            repeat (4) begin
               @(posedge iCLK);
               #1;
            end
            if ((cur == nack_target) && (nack_always || (nack_left > 0))) begin
               i2c_ack = 1'b1;
               if (nack_left > 0) begin
                  nack_left = nack_left - 1;
               end
            end else begin
               i2c_ack = 1'b0;
            end
            i2c_end = 1'b1;
         end
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] got,
                              input logic [31:0] exp);
      check_count++;
      if (got !== exp) begin
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
      end else begin
         pass_count++;
      end
   endtask

   // Single-cycle start pulse on the main instance.
   task automatic applyStimulus();
      @(posedge iCLK);
      #1;
      start = 1'b1;
      @(posedge iCLK);
      #1;
      start = 1'b0;
   endtask

   task automatic waitDone(input string tag, input int budget);
      int n;
      n = 0;
      while (!(done || error) && (n < budget)) begin
         @(posedge iCLK);
         #1;
         n++;
      end
      checkOutput({tag, " finished"}, 32'(done || error), 32'd1);
   endtask

   task automatic clearTable();
      for (int i = 0; i < 256; i++) begin
         rom[i] = 16'hFFFF;
      end
      log_q.delete();
      nack_target = 24'h0;
      nack_left   = 0;
      nack_always = 1'b0;
   endtask

   function automatic logic [23:0] logAt(input int i);
      if (i < log_q.size()) begin
         return log_q[i];
      end
      return 24'hxxxxxx;
   endfunction

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int n;
      iRST_N      = 1'b0;
      start       = 1'b0;
      start0      = 1'b0;
      start0_seen = 1'b0;
      clearTable();

      // Test 1: auto start after reset, all writes ACKed.
      rom[0] = 16'h0F08;
      rom[1] = 16'h6218;
      rom[2] = 16'hFFFF;
      repeat (3) @(posedge iCLK);
      #1;
      checkOutput("rst busy", 32'(busy), 32'd0);
      checkOutput("rst done", 32'(done), 32'd0);
      checkOutput("rst error", 32'(error), 32'd0);
      checkOutput("rst tbl_addr", 32'(tbl_addr), 32'd0);
      checkOutput("rst i2c_start", 32'(i2c_start), 32'd0);
      checkOutput("rst i2c_data", 32'(i2c_data), 32'd0);
      checkOutput("rst err_index", 32'(err_index), 32'd0);
      iRST_N = 1'b1;
      waitDone("t1", 300);
      checkOutput("t1 pulses", 32'(log_q.size()), 32'd2);
      checkOutput("t1 write0", 32'(logAt(0)), 32'h980F08);
      checkOutput("t1 write1", 32'(logAt(1)), 32'h986218);
      checkOutput("t1 done", 32'(done), 32'd1);
      checkOutput("t1 busy", 32'(busy), 32'd0);
      checkOutput("t1 error", 32'(error), 32'd0);

      // Test 2: second entry NACKed twice, third attempt ACKed.
      log_q.delete();
      nack_target = 24'h986218;
      nack_left   = 2;
      applyStimulus();
      checkOutput("t2 done cleared", 32'(done), 32'd0);
      waitDone("t2", 400);
      checkOutput("t2 pulses", 32'(log_q.size()), 32'd4);
      checkOutput("t2 write0", 32'(logAt(0)), 32'h980F08);
      checkOutput("t2 retry1", 32'(logAt(2)), 32'h986218);
      checkOutput("t2 retry2", 32'(logAt(3)), 32'h986218);
      checkOutput("t2 done", 32'(done), 32'd1);
      checkOutput("t2 error", 32'(error), 32'd0);

      // Test 3: entry 4 always NACKed -> three attempts then error.
      clearTable();
      rom[0] = 16'hA001;
      rom[1] = 16'hA102;
      rom[2] = 16'hA203;
      rom[3] = 16'hA304;
      rom[4] = 16'hA405;
      rom[5] = 16'hA506;
      nack_target = 24'h98A405;
      nack_always = 1'b1;
      applyStimulus();
      waitDone("t3", 600);
      checkOutput("t3 pulses", 32'(log_q.size()), 32'd7);
      checkOutput("t3 last write", 32'(logAt(6)), 32'h98A405);
      checkOutput("t3 error", 32'(error), 32'd1);
      checkOutput("t3 done", 32'(done), 32'd0);
      checkOutput("t3 err_index", 32'(err_index), 32'd4);
      checkOutput("t3 busy", 32'(busy), 32'd0);
      repeat (40) @(posedge iCLK);
      #1;
      checkOutput("t3 quiet after fail", 32'(log_q.size()), 32'd7);

      // Test 4: FE02 entry is a delay with the macro, a plain write without.
      clearTable();
      rom[0] = 16'hFE02;
      rom[1] = 16'hC001;
      applyStimulus();
      n = cyc;
      waitDone("t4", 400);
`ifdef I2C_INIT_SEQ_DELAY_EN
      checkOutput("t4 pulses", 32'(log_q.size()), 32'd1);
      checkOutput("t4 write0", 32'(logAt(0)), 32'h98C001);
      checkOutput("t4 gap", 32'((first_acc_cyc - n) >= 20), 32'd1);
`else
      checkOutput("t4 pulses", 32'(log_q.size()), 32'd2);
      checkOutput("t4 write0", 32'(logAt(0)), 32'h98FE02);
      checkOutput("t4 write1", 32'(logAt(1)), 32'h98C001);
`endif
      checkOutput("t4 done", 32'(done), 32'd1);

      // Test 5: start during the second transaction; it completes, then the
      // table reruns from index 0.
      clearTable();
      rom[0] = 16'h0F08;
      rom[1] = 16'h6218;
      rom[2] = 16'h7777;
      applyStimulus();
      n = 0;
      while ((log_q.size() < 2) && (n < 200)) begin
         @(posedge iCLK);
         #1;
         n++;
      end
      checkOutput("t5 reached entry 1", 32'(log_q.size() >= 2), 32'd1);
      applyStimulus();
      checkOutput("t5 still busy", 32'(busy), 32'd1);
      waitDone("t5", 600);
      checkOutput("t5 pulses", 32'(log_q.size()), 32'd5);
      checkOutput("t5 rerun write0", 32'(logAt(2)), 32'h980F08);
      checkOutput("t5 rerun write2", 32'(logAt(4)), 32'h987777);
      checkOutput("t5 done", 32'(done), 32'd1);
      checkOutput("t5 error", 32'(error), 32'd0);

      // Test 6: reset while i2c_start is high; manual instance stays idle.
      clearTable();
      rom[0] = 16'h0F08;
      applyStimulus();
      n = 0;
      while (!i2c_start && (n < 50)) begin
         @(posedge iCLK);
         #1;
         n++;
      end
      checkOutput("t6 request seen", 32'(i2c_start), 32'd1);
      iRST_N = 1'b0;
      #1;
      checkOutput("t6 i2c_start drop", 32'(i2c_start), 32'd0);
      checkOutput("t6 busy drop", 32'(busy), 32'd0);
      checkOutput("t6 tbl_addr", 32'(tbl_addr), 32'd0);
      repeat (10) @(posedge iCLK);
      #1;
      log_q.delete();
      iRST_N = 1'b1;
      waitDone("t6 auto rerun", 300);
      checkOutput("t6 rerun pulses", 32'(log_q.size()), 32'd1);
      checkOutput("t6 rerun write0", 32'(logAt(0)), 32'h980F08);
      checkOutput("t6 manual idle act", 32'(act0), 32'd0);
      checkOutput("t6 manual busy", 32'(busy0), 32'd0);
      checkOutput("t6 manual done", 32'(done0), 32'd0);
      @(posedge iCLK);
      #1;
      start0_seen = 1'b1;
      start0      = 1'b1;
      @(posedge iCLK);
      #1;
      start0 = 1'b0;
      checkOutput("t6 manual busy on start", 32'(busy0), 32'd1);
      repeat (10) @(posedge iCLK);
      #1;
      checkOutput("t6 manual done", 32'(done0), 32'd1);
      checkOutput("t6 manual busy end", 32'(busy0), 32'd0);

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
